// File: rtl/ps2_zx_pkg.sv
// Shared definitions for the PS/2 -> ZX Spectrum keyboard path: scancode
// constants, held-key slot enumeration, matrix type and the scancode map.
// Optional build macro: KBD_CURSOR_MAP_EN (cursor and Del keys as CS+digit).
package ps2_zx_pkg;

  // Prefix and control bytes of scancode set 2
  localparam logic [7:0] PFX_EXT    = 8'hE0;
  localparam logic [7:0] PFX_BRK    = 8'hF0;
  localparam logic [7:0] PFX_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BAT_OK  = 8'hAA;
  localparam logic [7:0] SC_ACK     = 8'hFA;
  localparam logic [7:0] SC_ECHO    = 8'hEE;
  localparam logic [7:0] SC_RESEND  = 8'hFE;
  localparam logic [7:0] SC_OVR_LO  = 8'h00;
  localparam logic [7:0] SC_OVR_HI  = 8'hFF;

  // Function keys
  localparam logic [7:0] SC_F1  = 8'h05;
  localparam logic [7:0] SC_F2  = 8'h06;
  localparam logic [7:0] SC_F3  = 8'h04;
  localparam logic [7:0] SC_F4  = 8'h0C;
  localparam logic [7:0] SC_F5  = 8'h03;
  localparam logic [7:0] SC_F6  = 8'h0B;
  localparam logic [7:0] SC_F7  = 8'h83;
  localparam logic [7:0] SC_F8  = 8'h0A;
  localparam logic [7:0] SC_F9  = 8'h01;
  localparam logic [7:0] SC_F10 = 8'h09;
  localparam logic [7:0] SC_F11 = 8'h78;

  // Bytes swallowed after the Pause prefix
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Number of held-key slots (K_NONE is not a slot)
  localparam int unsigned N_KEYS = 63;

  // Eight rows of five keys; a set bit means "pressed"
  typedef logic [7:0][4:0] matrix_t;

  // Held-key slots. The first 40 are in matrix order (row*5 + bit) so the
  // matrix can be read straight out of the slot vector.
  typedef enum logic [5:0] {
    K_CS, K_Z, K_X, K_C, K_V,
    K_A,  K_S, K_D, K_F, K_G,
    K_Q,  K_W, K_E, K_R, K_T,
    K_1,  K_2, K_3, K_4, K_5,
    K_0,  K_9, K_8, K_7, K_6,
    K_P,  K_O, K_I, K_U, K_Y,
    K_ENT, K_L, K_K, K_J, K_H,
    K_SP, K_SS, K_M, K_N, K_B,
    K_BKSP, K_LEFT, K_DOWN, K_UP, K_RIGHT, K_DEL,
    K_F1, K_F2, K_F3, K_F4, K_F5, K_F6, K_F7, K_F8, K_F9, K_F10, K_F11,
    K_LCTRL, K_RCTRL, K_LALT, K_RALT, K_LGUI, K_RGUI,
    K_NONE
  } key_id_t;

  // Translate a (possibly E0-extended) scancode into a held-key slot
  function automatic key_id_t sc_to_key(input logic ext, input logic [7:0] code);
    key_id_t k;
    k = K_NONE;
    if (!ext) begin
      case (code)
        8'h12: k = K_CS;   8'h1A: k = K_Z;   8'h22: k = K_X;   8'h21: k = K_C;   8'h2A: k = K_V;
        8'h1C: k = K_A;    8'h1B: k = K_S;   8'h23: k = K_D;   8'h2B: k = K_F;   8'h34: k = K_G;
        8'h15: k = K_Q;    8'h1D: k = K_W;   8'h24: k = K_E;   8'h2D: k = K_R;   8'h2C: k = K_T;
        8'h16: k = K_1;    8'h1E: k = K_2;   8'h26: k = K_3;   8'h25: k = K_4;   8'h2E: k = K_5;
        8'h45: k = K_0;    8'h46: k = K_9;   8'h3E: k = K_8;   8'h3D: k = K_7;   8'h36: k = K_6;
        8'h4D: k = K_P;    8'h44: k = K_O;   8'h43: k = K_I;   8'h3C: k = K_U;   8'h35: k = K_Y;
        8'h5A: k = K_ENT;  8'h4B: k = K_L;   8'h42: k = K_K;   8'h3B: k = K_J;   8'h33: k = K_H;
        8'h29: k = K_SP;   8'h59: k = K_SS;  8'h3A: k = K_M;   8'h31: k = K_N;   8'h32: k = K_B;
        8'h66: k = K_BKSP;
        8'h14: k = K_LCTRL;
        8'h11: k = K_LALT;
        SC_F1: k = K_F1;   SC_F2: k = K_F2;  SC_F3: k = K_F3;  SC_F4: k = K_F4;
        SC_F5: k = K_F5;   SC_F6: k = K_F6;  SC_F7: k = K_F7;  SC_F8: k = K_F8;
        SC_F9: k = K_F9;   SC_F10: k = K_F10; SC_F11: k = K_F11;
        default: k = K_NONE;
      endcase
    end else begin
      case (code)
        8'h14: k = K_RCTRL;
        8'h11: k = K_RALT;
        8'h1F: k = K_LGUI;
        8'h27: k = K_RGUI;
`ifdef KBD_CURSOR_MAP_EN
        8'h6B: k = K_LEFT;
        8'h72: k = K_DOWN;
        8'h75: k = K_UP;
        8'h74: k = K_RIGHT;
        8'h71: k = K_DEL;
`endif
        default: k = K_NONE;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/ps2_zx_keyboard_rx.sv
// PS/2 receiver: synchronises the raw lines, deframes 11-bit frames,
// checks start/parity/stop and discards stalled partial frames.
module ps2_rx #(
  parameter int unsigned TIMEOUT_CYC = 56000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_prev_q;
  logic [3:0]    cnt_q, cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          fall;
  logic          data_s;

  assign data_s = data_sync_q[1];
  assign fall   = clk_prev_q & ~clk_sync_q[1];

  // Two-flop synchronisers and the delayed clock used for edge detection
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of order.
    if (!rst_ni) begin
      // NOTE: synchroniser flops reset to the idle-high line level so that
      // leaving reset never manufactures a falling edge.
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  // Framing, parity check and stall timeout
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tmo_d   = tmo_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (fall) begin
      tmo_d = '0;
      if (cnt_q == 4'd10) begin
        cnt_d = 4'd0;
        // start=0, stop=1, odd parity over data+parity
        if (!shift_q[0] && data_s && (^shift_q[9:1])) begin
          byte_d  = shift_q[8:1];
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        shift_d[cnt_q] = data_s;
        cnt_d          = cnt_q + 4'd1;
      end
    end else if (cnt_q != 4'd0) begin
      if (tmo_q == TMO_LAST) begin
        cnt_d = 4'd0;
        tmo_d = '0;
        err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Receiver state registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= 4'd0;
      shift_q <= '0;
      tmo_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      tmo_q   <= tmo_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_zx_keyboard.sv
// PS/2 to ZX Spectrum 8x5 key matrix, with function-key and modifier levels.
// Optional build macro: KBD_CURSOR_MAP_EN (cursor and Del keys as CS+digit).
module ps2_zx_keyboard
  import ps2_zx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 56000
) (
  input  logic        clk_sys,
  input  logic        nRESET,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [15:0] addr,
  output logic [4:0]  key_data,
  output logic [11:1] Fn,
  output logic [2:0]  mod,
  output logic        key_strobe,
  output logic        frame_err
);

  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic [N_KEYS-1:0] held_q, held_d;
  logic              ext_q, ext_d;
  logic              brk_q, brk_d;
  logic [2:0]        skip_q, skip_d;
  logic              strobe_q, strobe_d;
  logic [4:0]        key_data_q, key_data_d;
  matrix_t           matrix;
  key_id_t           key;
  logic              unused_addr;

  assign unused_addr = ^addr[7:0];

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk_i        (clk_sys),
    .rst_ni       (nRESET),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (frame_err)
  );

  assign key = sc_to_key(ext_q, rx_byte);

  // Scancode decoder: prefix flags, Pause skipping and per-key held bits
  always_comb begin
    held_d   = held_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    skip_d   = skip_q;
    strobe_d = 1'b0;
    if (rx_valid) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (rx_byte)
          PFX_EXT:   ext_d  = 1'b1;
          PFX_BRK:   brk_d  = 1'b1;
          PFX_PAUSE: skip_d = PAUSE_SKIP;
          SC_BAT_OK, SC_ACK, SC_ECHO, SC_RESEND: begin
          end
          SC_OVR_LO, SC_OVR_HI: begin
            held_d = '0;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end
          default: begin
            if (key != K_NONE) begin
              if (!brk_q) begin
                held_d[key] = 1'b1;
                strobe_d    = 1'b1;
              end else if (held_q[key]) begin
                held_d[key] = 1'b0;
                strobe_d    = 1'b1;
              end
            end
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        endcase
      end
    end
  end

  // Matrix derived from held slots; composite keys OR into two bits each
  always_comb begin
    matrix = '0;
    for (int i = 0; i < 40; i++) begin
      matrix[i / 5][i % 5] = held_q[i];
    end
    matrix[0][0] = matrix[0][0] | held_q[K_BKSP] | held_q[K_DEL] | held_q[K_LEFT]
                 | held_q[K_DOWN] | held_q[K_UP] | held_q[K_RIGHT];
    matrix[4][0] = matrix[4][0] | held_q[K_BKSP] | held_q[K_DEL];
    matrix[3][4] = matrix[3][4] | held_q[K_LEFT];
    matrix[4][4] = matrix[4][4] | held_q[K_DOWN];
    matrix[4][3] = matrix[4][3] | held_q[K_UP];
    matrix[4][2] = matrix[4][2] | held_q[K_RIGHT];
  end

  // Active-low AND of every row whose address line is low
  always_comb begin
    key_data_d = 5'h1F;
    for (int r = 0; r < 8; r++) begin
      if (!addr[8 + r]) key_data_d = key_data_d & ~matrix[r];
    end
  end

  // Decoder and read-port registers; reset wins over a same-cycle byte
  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      held_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skip_q     <= 3'd0;
      strobe_q   <= 1'b0;
      key_data_q <= 5'h1F;
    end else begin
      held_q     <= held_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      skip_q     <= skip_d;
      strobe_q   <= strobe_d;
      key_data_q <= key_data_d;
    end
  end

  assign key_data   = key_data_q;
  assign key_strobe = strobe_q;
  assign Fn         = held_q[int'(K_F11):int'(K_F1)];
  assign mod        = {held_q[K_LGUI]  | held_q[K_RGUI],
                       held_q[K_LALT]  | held_q[K_RALT],
                       held_q[K_LCTRL] | held_q[K_RCTRL]};

endmodule

// File: tb/tb_ps2_zx_keyboard.sv
// Self-checking bench for ps2_zx_keyboard: directed scenarios followed by
// randomized key traffic compared against a key-set reference model.
`timescale 1ns/1ps
module tb_ps2_zx_keyboard;

  localparam int TMO  = 800;
  localparam int HALF = 4;

  logic        clk_sys  = 1'b0;
  logic        nRESET   = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] addr     = 16'hFFFE;
  logic [4:0]  key_data;
  logic [11:1] Fn;
  logic [2:0]  mod;
  logic        key_strobe;
  logic        frame_err;

  ps2_zx_keyboard #(.TIMEOUT_CYC(TMO)) dut (
    .clk_sys    (clk_sys),
    .nRESET     (nRESET),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .addr       (addr),
    .key_data   (key_data),
    .Fn         (Fn),
    .mod        (mod),
    .key_strobe (key_strobe),
    .frame_err  (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;
  int n_strobe = 0;
  int n_err    = 0;

  always @(negedge clk_sys) begin
    if (key_strobe) n_strobe++;
    if (frame_err)  n_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Keys held, indexed by {ext, code}; the matrix is rebuilt from this set.
  localparam logic [7:0] MAP40 [40] = '{
    8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,
    8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
    8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
    8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
    8'h29, 8'h59, 8'h3A, 8'h31, 8'h32};
  localparam logic [7:0] FTAB [11] = '{
    8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78};
  localparam logic [7:0] MISC [9] = '{
    8'h66, 8'h14, 8'h11, 8'h0D, 8'h76, 8'h1F, 8'h7C, 8'h5A, 8'h4A};
  localparam logic [7:0] EXTS [11] = '{
    8'h14, 8'h11, 8'h1F, 8'h27, 8'h6B, 8'h72, 8'h75, 8'h74, 8'h71, 8'h5A, 8'h70};
  localparam logic [7:0] IGN [4] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE};

  bit m_held [512];
  bit m_ext, m_brk;
  int m_skip, m_strobes;

  // Matrix positions (row*5+bit), function index and modifier index of a key
  function automatic void targets(input bit ext, input logic [7:0] b,
                                  output int p0, output int p1, output int fn, output int md);
    p0 = -1; p1 = -1; fn = 0; md = -1;
    if (!ext) begin
      for (int i = 0; i < 40; i++) if (MAP40[i] == b) p0 = i;
      for (int i = 0; i < 11; i++) if (FTAB[i] == b) fn = i + 1;
      if (b == 8'h66) begin p0 = 0; p1 = 20; end
      if (b == 8'h14) md = 0;
      if (b == 8'h11) md = 1;
    end else begin
      case (b)
        8'h14: md = 0;
        8'h11: md = 1;
        8'h1F, 8'h27: md = 2;
`ifdef KBD_CURSOR_MAP_EN
        8'h6B: begin p0 = 0; p1 = 19; end
        8'h72: begin p0 = 0; p1 = 24; end
        8'h75: begin p0 = 0; p1 = 23; end
        8'h74: begin p0 = 0; p1 = 22; end
        8'h71: begin p0 = 0; p1 = 20; end
`endif
        default: ;
      endcase
    end
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 512; k++) m_held[k] = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int p0, p1, fn, md, k;
    if (m_skip > 0) begin
      m_skip--;
      return;
    end
    case (b)
      8'hE0: m_ext = 1'b1;
      8'hF0: m_brk = 1'b1;
      8'hE1: m_skip = 7;
      8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
      8'h00, 8'hFF: begin
        for (int j = 0; j < 512; j++) m_held[j] = 1'b0;
        m_ext = 1'b0; m_brk = 1'b0;
      end
      default: begin
        targets(m_ext, b, p0, p1, fn, md);
        k = {23'd0, m_ext, b};
        if (p0 >= 0 || fn > 0 || md >= 0) begin
          if (!m_brk) begin
            m_held[k] = 1'b1; m_strobes++;
          end else if (m_held[k]) begin
            m_held[k] = 1'b0; m_strobes++;
          end
        end
        m_ext = 1'b0; m_brk = 1'b0;
      end
    endcase
  endtask

  task automatic model_outputs(input logic [15:0] a, output logic [4:0] kd,
                               output logic [11:1] fv, output logic [2:0] mv);
    bit m [40];
    int p0, p1, fn, md;
    logic [8:0] kk;
    kd = 5'h1F; fv = '0; mv = '0;
    for (int i = 0; i < 40; i++) m[i] = 1'b0;
    for (int k = 0; k < 512; k++) begin
      if (m_held[k]) begin
        kk = 9'(k);
        targets(kk[8], kk[7:0], p0, p1, fn, md);
        if (p0 >= 0) m[p0] = 1'b1;
        if (p1 >= 0) m[p1] = 1'b1;
        if (fn > 0)  fv[fn] = 1'b1;
        if (md >= 0) mv[md] = 1'b1;
      end
    end
    for (int i = 0; i < 40; i++) if (m[i] && !a[8 + i / 5]) kd[i % 5] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic ps2_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      repeat (HALF) @(negedge clk_sys);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk_sys);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ps2_bits(mk_frame(b, 1'b0), 11);
    model_byte(b);
    repeat (6) @(negedge clk_sys);
  endtask

  task automatic set_addr(input logic [15:0] a);
    addr = a;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    nRESET = 1'b0;
    @(negedge clk_sys);
    nRESET = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_sys);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, e0, ms0, r;
    logic [7:0] code, sel;
    logic [4:0] ekd;
    logic [11:1] efn;
    logic [2:0] emd;
    bit ext, brk;

    model_reset();
    m_strobes = 0;
    repeat (4) @(negedge clk_sys);
    nRESET = 1'b1;
    repeat (3) @(negedge clk_sys);
    set_addr(16'h00FE);
    check("reset_kd", 32'(key_data), 32'h1F);
    check("reset_fn", 32'(Fn), 32'h0);
    check("reset_mod", 32'(mod), 32'h0);
    check("reset_strobe", 32'(key_strobe), 32'h0);
    check("reset_err", 32'(frame_err), 32'h0);

    // A make / break
    set_addr(16'hFDFE);
    s0 = n_strobe;
    send_byte(8'h1C);
    check("a_make", 32'(key_data), 32'h1E);
    send_byte(8'hF0); send_byte(8'h1C);
    check("a_break", 32'(key_data), 32'h1F);
    check("a_strobes", 32'(n_strobe - s0), 32'd2);

    // CS+Z, multi-row read, partial release
    set_addr(16'hFEFE);
    send_byte(8'h12); send_byte(8'h1A);
    check("cs_z", 32'(key_data), 32'h1C);
    send_byte(8'h1C);
    set_addr(16'h00FE);
    check("all_rows", 32'(key_data), 32'h1C);
    send_byte(8'hF0); send_byte(8'h12);
    set_addr(16'hFEFE);
    check("cs_release", 32'(key_data), 32'h1D);
    send_byte(8'hF0); send_byte(8'h1A);
    send_byte(8'hF0); send_byte(8'h1C);

    // Bad parity, then stalled partial frame, then a good frame
    set_addr(16'hFDFE);
    e0 = n_err;
    ps2_bits(mk_frame(8'h1C, 1'b1), 11);
    repeat (8) @(negedge clk_sys);
    check("parity_err", 32'(n_err - e0), 32'd1);
    check("parity_kd", 32'(key_data), 32'h1F);
    e0 = n_err;
    ps2_bits(mk_frame(8'h1C, 1'b0), 5);
    repeat (TMO + 10) @(negedge clk_sys);
    send_byte(8'h1C);
    check("timeout_err", 32'(n_err - e0), 32'd1);
    check("timeout_kd", 32'(key_data), 32'h1E);
    send_byte(8'hF0); send_byte(8'h1C);

    // Ctrl + F11, overrun
    send_byte(8'h14); send_byte(8'h78);
    check("ctrl_mod", 32'(mod), 32'h1);
    check("f11_fn", 32'(Fn), 32'h400);
    send_byte(8'hF0); send_byte(8'h78);
    check("f11_rel", 32'(Fn), 32'h0);
    check("ctrl_kept", 32'(mod), 32'h1);
    send_byte(8'h00);
    check("overrun_mod", 32'(mod), 32'h0);

    // Cursor up
    send_byte(8'hE0); send_byte(8'h75);
    set_addr(16'hFEFE);
`ifdef KBD_CURSOR_MAP_EN
    check("up_cs", 32'(key_data), 32'h1E);
    set_addr(16'hEFFE);
    check("up_7", 32'(key_data), 32'h17);
`else
    check("up_cs", 32'(key_data), 32'h1F);
    set_addr(16'hEFFE);
    check("up_7", 32'(key_data), 32'h1F);
`endif
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);

    // Reset mid-frame with a key held
    set_addr(16'hFDFE);
    send_byte(8'h1C);
    check("pre_rst_kd", 32'(key_data), 32'h1E);
    e0 = n_err;
    ps2_bits(mk_frame(8'h5A, 1'b0), 5);
    do_reset();
    check("rst_kd", 32'(key_data), 32'h1F);
    repeat (20) @(negedge clk_sys);
    send_byte(8'h1C);
    check("post_rst_kd", 32'(key_data), 32'h1E);
    check("post_rst_err", 32'(n_err - e0), 32'd0);

    // Randomized traffic against the model
    for (int it = 0; it < 150; it++) begin
      s0 = n_strobe;
      ms0 = m_strobes;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        send_byte(8'h00);
      end else if (r < 5) begin
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
      end else if (r < 8) begin
        send_byte(IGN[$urandom_range(0, 3)]);
      end else if (r < 12) begin
        send_byte(8'($urandom_range(0, 255)));
      end else begin
        ext = ($urandom_range(0, 3) == 0);
        if (ext) begin
          code = EXTS[$urandom_range(0, 10)];
        end else begin
          r = $urandom_range(0, 59);
          if (r < 40)      code = MAP40[r];
          else if (r < 51) code = FTAB[r - 40];
          else             code = MISC[r - 51];
        end
        brk = ($urandom_range(0, 9) < 4);
        if (ext) send_byte(8'hE0);
        if (brk) send_byte(8'hF0);
        send_byte(code);
      end
      if ($urandom_range(0, 3) == 0) begin
        sel = 8'($urandom_range(0, 255));
      end else begin
        sel = ~(8'h01 << $urandom_range(0, 7));
      end
      set_addr({sel, 8'hFE});
      model_outputs(addr, ekd, efn, emd);
      check("rnd_kd", 32'(key_data), 32'(ekd));
      check("rnd_fn", 32'(Fn), 32'(efn));
      check("rnd_mod", 32'(mod), 32'(emd));
      check("rnd_strobe", 32'(n_strobe - s0), 32'(m_strobes - ms0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
